// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter serialising read/write transactions onto a 16x4 synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration of simultaneous requests; otherwise port 0 has fixed priority.
module ram_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [3:0] addr0,
   input  logic [3:0] addr1,
   input  logic [3:0] wdata0,
   input  logic [3:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       rsp_valid0,
   output logic       rsp_valid1,
   output logic [3:0] rdata,
   output logic       busy,
   output logic       mem_we,
   output logic [3:0] mem_add,
   output logic [3:0] mem_din,
   input  logic [3:0] mem_dout
);
   typedef enum logic [2:0] {IDLE, W0, W1, W2, R0, R1} state_t;
   state_t state, state_nxt;
   logic   owner;
   logic   pick1;
`ifdef RAM_ARB_RR_EN
   logic   last;
   // on a tie the port that was not granted most recently wins
   always_comb pick1 = req1 & (~req0 | ~last);
   // track the most recently granted port; reset behaves as if port 1 was granted last
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= 1'b1;
      else if (gnt0 | gnt1) last <= gnt1;
`else
   // port 0 wins every tie
   always_comb pick1 = req1 & ~req0;
`endif
   assign busy   = state != IDLE;
   assign mem_we = state == W0;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // next state and grants; grants only come from IDLE and are suppressed while reset is asserted
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         IDLE: if (rst_n && (req0 || req1)) begin
            gnt0      = ~pick1;
            gnt1      = pick1;
            state_nxt = (pick1 ? we1 : we0) ? W0 : R0;
         end
         W0:      state_nxt = W1;
         W1:      state_nxt = W2;
         W2:      state_nxt = IDLE;
         R0:      state_nxt = R1;
         R1:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // capture the granted port and its request; mem_add/mem_din stay put until the next grant
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         owner   <= 1'b0;
         mem_add <= 4'h0;
         mem_din <= 4'h0;
      end else if (gnt0 | gnt1) begin
         owner   <= gnt1;
         mem_add <= gnt1 ? addr1 : addr0;
         mem_din <= gnt1 ? wdata1 : wdata0;
      end
   // read response: take RAM data at the edge ending R1 and pulse the owner's valid for one cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         rdata      <= 4'h0;
      end else begin
         rsp_valid0 <= (state == R1) & ~owner;
         rsp_valid1 <= (state == R1) & owner;
         if (state == R1) rdata <= mem_dout;
      end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter with a behavioural 16x4 RAM.
module tb_ram_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we;
   logic [3:0] rdata, mem_add, mem_din;
   logic [3:0] mem_dout = 4'h0;
   logic [3:0] ram [16];
   logic       we_d1 = 1'b0, we_d2 = 1'b0;
   int         cyc = 0;
   int         n_chk = 0, n_fail = 0;

   typedef struct {bit p; logic [3:0] d; int c;} exp_t;
   exp_t       sq [$];
   logic [7:0] wq [$];
   bit         gord [$];

   ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rdata(rdata), .busy(busy), .mem_we(mem_we), .mem_add(mem_add),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM with a two-stage write-enable pipeline and registered read data
   initial for (int i = 0; i < 16; i++) ram[i] = 4'h0;
   always @(posedge clk) begin
      we_d1 <= mem_we;
      we_d2 <= we_d1;
      if (we_d2) ram[mem_add] <= mem_din;
      mem_dout <= ram[mem_add];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // raise a request, wait for its grant, record expectations, drop the request after the grant edge
   task automatic do_req(input bit p, input bit w, input logic [3:0] a, input logic [3:0] d,
                         input bit exp_rsp, output int waited);
      int n = 0;
      if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
      else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      @(negedge clk);
      while (!(p ? gnt1 : gnt0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      chk(p ? "gnt1_arrived" : "gnt0_arrived", {31'b0, (p ? gnt1 : gnt0)}, 1);
      gord.push_back(p);
      if (w) wq.push_back({a, d});
      else if (exp_rsp) sq.push_back('{p, d, cyc + 3});
      @(posedge clk);
      #1;
      if (p) req1 = 1'b0; else req0 = 1'b0;
   endtask

   // response monitor: pops the scoreboard whenever a rsp_valid pulses
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         chk("gnt_onehot", {31'b0, gnt0 & gnt1}, 0);
         chk("gnt_while_busy", {31'b0, (gnt0 | gnt1) & busy}, 0);
         if (rsp_valid0 | rsp_valid1) begin
            if (sq.size() == 0) chk("rsp_unexpected", {30'b0, rsp_valid0, rsp_valid1}, 0);
            else begin
               e = sq.pop_front();
               chk("rsp_port", {30'b0, rsp_valid0, rsp_valid1}, e.p ? 2'b01 : 2'b10);
               chk("rsp_data", {28'b0, rdata}, {28'b0, e.d});
               chk("rsp_latency", cyc, e.c);
            end
         end
      end
   end

   // write monitor: one mem_we cycle per granted write, address/data stable through W2
   initial begin : wmon
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            if (wq.size() == 0) chk("we_unexpected", {31'b0, mem_we}, 0);
            else begin
               e = wq.pop_front();
               chk("w0_add_din", {24'b0, mem_add, mem_din}, {24'b0, e});
               repeat (2) begin
                  @(negedge clk);
                  chk("w12_we_low", {31'b0, mem_we}, 0);
                  chk("w12_add_din_hold", {24'b0, mem_add, mem_din}, {24'b0, e});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      int w, wa, wb;
      logic [7:0] gv, gexp;
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 4'h0; addr1 = 4'h0; wdata0 = 4'h0; wdata1 = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {17'b0, gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we, mem_add, mem_din, rdata}, 0);
      req0 = 1'b0;
      rst_n = 1'b1;
      // write 5=A then read it back on port 0, request held across transactions
      do_req(0, 1, 4'h5, 4'hA, 0, w);
      do_req(0, 0, 4'h5, 4'hA, 1, w);
      chk("regrant_after_write", w, 3);
      do_req(0, 0, 4'h5, 4'hA, 1, w);
      chk("regrant_after_read", w, 2);
      // preload 1=3 from port 0 and 2=7 from port 1
      do_req(0, 1, 4'h1, 4'h3, 0, w);
      do_req(1, 1, 4'h2, 4'h7, 0, w);
      // both ports read continuously
      gord.delete();
      fork
         begin int x; for (int i = 0; i < 4; i++) do_req(0, 0, 4'h1, 4'h3, 1, x); end
         begin int y; for (int i = 0; i < 4; i++) do_req(1, 0, 4'h2, 4'h7, 1, y); end
      join
      gv = 8'h0;
      foreach (gord[i]) gv = {gv[6:0], gord[i]};
`ifdef RAM_ARB_RR_EN
      gexp = 8'b0101_0101;
`else
      gexp = 8'b0000_1111;
`endif
      chk("grant_count", gord.size(), 8);
      chk("grant_order", {24'b0, gv}, {24'b0, gexp});
      // address extremes: F and 0 are independent locations
      do_req(0, 1, 4'hF, 4'h9, 0, w);
      do_req(1, 1, 4'h0, 4'h5, 0, w);
      do_req(0, 0, 4'hF, 4'h9, 1, w);
      do_req(1, 0, 4'h0, 4'h5, 1, w);
      repeat (4) @(posedge clk);
      #1;
      // reset during R0 aborts the read with no response
      do_req(0, 0, 4'h5, 4'hA, 0, w);
      rst_n = 1'b0;
      #1;
      chk("reset_in_r0_outputs", {17'b0, gnt0, gnt1, rsp_valid0, rsp_valid1, busy, mem_we, mem_add, mem_din, rdata}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_req(1, 0, 4'h5, 4'hA, 1, w);
      chk("first_gnt_after_reset", w, 0);
      repeat (3) @(posedge clk);
      #1;
      // write 3=4 on port 0, then port 1 reads 3 while the write is in flight
      fork
         do_req(0, 1, 4'h3, 4'h4, 0, wa);
         begin @(posedge clk); #1; do_req(1, 0, 4'h3, 4'h4, 1, wb); end
         begin : bsy
            int n;
            logic [7:0] bv;
            n = 0;
            bv = 8'h0;
            @(negedge clk);
            while (!gnt0 && n < 10) begin @(negedge clk); n++; end
            bv[7] = busy;
            for (int i = 6; i >= 0; i--) begin @(negedge clk); bv[i] = busy; end
            chk("busy_sequence", {24'b0, bv}, {24'b0, 8'b0111_0110});
         end
      join
      chk("read_after_write_wait", wb, 3);
      repeat (6) @(posedge clk);
      chk("scoreboard_drained", sq.size(), 0);
      chk("writes_drained", wq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
